aq_idu_gpr_scoreboard: RTL and testbench
========================================

AQ_IDU_GPR_SCOREBOARD -- requirements
Module: aq_idu_gpr_scoreboard

Interface
REQ-001 SHALL have port forever_cpuclk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port cpurst_b, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port idu_sb_dp_vld, input, 1, instruction presented for dispatch.
REQ-004 SHALL have ports idu_sb_dp_rd_vld (1) and idu_sb_dp_rd (5), inputs, destination GPR write enable and index.
REQ-005 SHALL have ports idu_sb_dp_rs1_vld (1), idu_sb_dp_rs1 (5), idu_sb_dp_rs2_vld (1) and idu_sb_dp_rs2 (5), inputs, source GPR use and index.
REQ-006 SHALL have ports alu_sb_wb_vld (1) and alu_sb_wb_rd (5), inputs, ALU/MUL writeback release.
REQ-007 SHALL have ports lsu_sb_wb_vld (1) and lsu_sb_wb_rd (5), inputs, load writeback release.
REQ-008 SHALL have port rtu_sb_flush, input, 1, pipeline flush.
REQ-009 SHALL have port sb_idu_stall, output, 1, dispatch blocked this cycle.
REQ-010 SHALL have ports sb_top_busy (output, 32, per-GPR busy vector), sb_top_busy_cnt (output, 6, number of busy GPRs) and sb_top_empty (output, 1, no GPR busy).

Function
REQ-011 SHALL hold a 32-bit busy register; bit 0 (x0) SHALL be constant 0 and never set.
REQ-012 SHALL define dispatch fire = idu_sb_dp_vld & !sb_idu_stall.
REQ-013 SHALL assert sb_idu_stall when idu_sb_dp_vld and any of: rs1_vld & busy[rs1]; rs2_vld & busy[rs2]; rd_vld & busy[rd] (WAW); rtu_sb_flush.
REQ-014 SHALL set busy[rd] on the next edge when dispatch fires with rd_vld and rd != 0.
REQ-015 SHALL clear busy[x] on the next edge for each valid writeback with rd x; ALU and LSU clears on different indices SHALL both take effect in the same cycle.
REQ-016 SHALL treat identical ALU and LSU writeback indices in one cycle as a single clear.
REQ-017 SHALL let a set win when a set and a clear target the same index in the same cycle.
REQ-018 SHALL clear all busy bits on the next edge when rtu_sb_flush is high, ignoring every set and clear in that cycle; the flush takes priority.
REQ-019 SHALL maintain sb_top_busy_cnt as a register updated in the same edge as busy: +1 per effective set, -1 per effective clear of a set bit; it SHALL always equal the popcount of busy.
REQ-020 SHALL ignore writebacks to x0 or to a non-busy register (no count change).
REQ-021 SHALL drive sb_top_empty = (sb_top_busy_cnt == 0) from registered state.

Reset
REQ-022 SHALL, on cpurst_b low, asynchronously clear busy to 32'h0 and sb_top_busy_cnt to 0, giving sb_top_empty=1 and sb_idu_stall=0 (absent flush).
REQ-023 SHALL, after reset deassertion mid-operation, ignore all writebacks of producers dispatched before reset.

Configuration
REQ-024 SHALL, when macro AQ_IDU_SB_WB_BYPASS_EN is defined, compute hazards from busy & ~(same-cycle writeback clears), so a source released this cycle does not stall.
REQ-025 SHALL, without AQ_IDU_SB_WB_BYPASS_EN, compute hazards from registered busy only (one extra stall cycle after writeback); the set/clear behaviour SHALL be identical in both builds.

Structure
REQ-026 SHALL place the GPR count (32), index width (5) and count width (6) constants in the shared IDU package.
REQ-027 SHALL decode each of rd, rs1, rs2 and both writeback indices to one-hot through instances of aq_idu_expand_32; no other sub-module.

Verification
REQ-028 SHALL cover: reset, then dispatch rd=5 -> busy=32'h20, cnt=1, empty=0 next cycle.
REQ-029 SHALL cover: busy[5]=1, dispatch rs1=5 -> stall=1; alu wb rd=5 -> with bypass, stall=0 same cycle; without bypass, stall=0 one cycle later.
REQ-030 SHALL cover: dispatch rd=7 while lsu wb rd=7 and busy[7]=1 -> busy[7] stays 1 (WAW stall blocks fire; retry next cycle sets it, cnt unchanged net).
REQ-031 SHALL cover: busy={3,9}, alu wb 3 and lsu wb 9 same cycle -> busy=0, cnt=0, empty=1.
REQ-032 SHALL cover: busy={1,2,31}, flush with concurrent dispatch rd=4 -> busy=0, cnt=0, stall=1 in flush cycle.
REQ-033 SHALL cover: dispatch rd=0, then wb rd=0 -> busy stays 0, cnt stays 0.

Source files
------------

// File: rtl/aq_idu_gpr_scoreboard_pkg.sv
// Shared IDU constants and types for the GPR scoreboard.
// Holds the GPR count/width constants and a popcount helper.
package aq_idu_gpr_scoreboard_pkg;
   localparam int GPR_NUM   = 32;
   localparam int GPR_IDX_W = 5;
   localparam int GPR_CNT_W = 6;

   typedef logic [GPR_NUM-1:0]   gpr_vec_t;
   typedef logic [GPR_IDX_W-1:0] gpr_idx_t;
   typedef logic [GPR_CNT_W-1:0] gpr_cnt_t;

   function automatic gpr_cnt_t popcnt(input gpr_vec_t v);
      gpr_cnt_t c;
      c = '0;
      for (int i = 0; i < GPR_NUM; i++) c = c + gpr_cnt_t'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/aq_idu_expand_32.sv
// 5-to-32 one-hot decoder used for every GPR index in the scoreboard.
module aq_idu_expand_32
   import aq_idu_gpr_scoreboard_pkg::*;
(
   input  gpr_idx_t idx,
   output gpr_vec_t onehot
);
   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end
endmodule

// File: rtl/aq_idu_gpr_scoreboard.sv
// GPR busy scoreboard: blocks dispatch on RAW/WAW hazards, released by ALU/LSU writeback.
// AQ_IDU_SB_WB_BYPASS_EN lets same-cycle writebacks mask hazards.
module aq_idu_gpr_scoreboard
   import aq_idu_gpr_scoreboard_pkg::*;
(
   input  logic           forever_cpuclk,
   input  logic           cpurst_b,
   input  logic           idu_sb_dp_vld,
   input  logic           idu_sb_dp_rd_vld,
   input  gpr_idx_t       idu_sb_dp_rd,
   input  logic           idu_sb_dp_rs1_vld,
   input  gpr_idx_t       idu_sb_dp_rs1,
   input  logic           idu_sb_dp_rs2_vld,
   input  gpr_idx_t       idu_sb_dp_rs2,
   input  logic           alu_sb_wb_vld,
   input  gpr_idx_t       alu_sb_wb_rd,
   input  logic           lsu_sb_wb_vld,
   input  gpr_idx_t       lsu_sb_wb_rd,
   input  logic           rtu_sb_flush,
   output logic           sb_idu_stall,
   output gpr_vec_t       sb_top_busy,
   output gpr_cnt_t       sb_top_busy_cnt,
   output logic           sb_top_empty
);
   gpr_vec_t busy, hzd, wb_clr, set_vec, new_set, clr_vec;
   gpr_vec_t rd_oh, rs1_oh, rs2_oh, alu_oh, lsu_oh;
   gpr_cnt_t cnt;
   logic     hazard, fire;

   aq_idu_expand_32 u_rd  (.idx(idu_sb_dp_rd),  .onehot(rd_oh));
   aq_idu_expand_32 u_rs1 (.idx(idu_sb_dp_rs1), .onehot(rs1_oh));
   aq_idu_expand_32 u_rs2 (.idx(idu_sb_dp_rs2), .onehot(rs2_oh));
   aq_idu_expand_32 u_alu (.idx(alu_sb_wb_rd),  .onehot(alu_oh));
   aq_idu_expand_32 u_lsu (.idx(lsu_sb_wb_rd),  .onehot(lsu_oh));

   // OR-ing the two one-hots merges identical ALU/LSU indices into one clear.
   assign wb_clr = ({GPR_NUM{alu_sb_wb_vld}} & alu_oh) | ({GPR_NUM{lsu_sb_wb_vld}} & lsu_oh);

`ifdef AQ_IDU_SB_WB_BYPASS_EN
   assign hzd = busy & ~wb_clr;
`else
   assign hzd = busy;
`endif

   assign hazard = (idu_sb_dp_rs1_vld & |(hzd & rs1_oh))
                 | (idu_sb_dp_rs2_vld & |(hzd & rs2_oh))
                 | (idu_sb_dp_rd_vld  & |(hzd & rd_oh));

   assign sb_idu_stall = idu_sb_dp_vld & (hazard | rtu_sb_flush);
   assign fire         = idu_sb_dp_vld & ~sb_idu_stall;

   // x0 is masked out of the set; a set beats a same-index clear.
   assign set_vec = {GPR_NUM{fire & idu_sb_dp_rd_vld}} & rd_oh & {{(GPR_NUM-1){1'b1}}, 1'b0};
   assign new_set = set_vec & ~busy;
   assign clr_vec = wb_clr & busy & ~set_vec;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         busy <= '0;
         cnt  <= '0;
      end else if (rtu_sb_flush) begin
         busy <= '0;
         cnt  <= '0;
      end else begin
         busy <= (busy | set_vec) & ~clr_vec;
         cnt  <= cnt + popcnt(new_set) - popcnt(clr_vec);
      end
   end

   assign sb_top_busy     = busy;
   assign sb_top_busy_cnt = cnt;
   assign sb_top_empty    = (cnt == '0);
endmodule

// File: tb/tb_aq_idu_gpr_scoreboard.sv
// Self-checking bench for aq_idu_gpr_scoreboard: directed scenarios plus random traffic
// against an array-based reference model (honours AQ_IDU_SB_WB_BYPASS_EN).
module tb_aq_idu_gpr_scoreboard;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dv, rdv, r1v, r2v, av, lv, fl;
   logic [4:0]  rd, r1, r2, ar, lr;
   logic        stall, empty;
   logic [31:0] busy;
   logic [5:0]  cnt;

   int n_vec = 0;
   int n_err = 0;
   bit bm[32];
   bit exp_stall;
   int saved_cnt;

   always #5 clk = ~clk;

   aq_idu_gpr_scoreboard dut (
      .forever_cpuclk(clk), .cpurst_b(rst_n),
      .idu_sb_dp_vld(dv), .idu_sb_dp_rd_vld(rdv), .idu_sb_dp_rd(rd),
      .idu_sb_dp_rs1_vld(r1v), .idu_sb_dp_rs1(r1),
      .idu_sb_dp_rs2_vld(r2v), .idu_sb_dp_rs2(r2),
      .alu_sb_wb_vld(av), .alu_sb_wb_rd(ar),
      .lsu_sb_wb_vld(lv), .lsu_sb_wb_rd(lr),
      .rtu_sb_flush(fl), .sb_idu_stall(stall),
      .sb_top_busy(busy), .sb_top_busy_cnt(cnt), .sb_top_empty(empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mvec();
      logic [31:0] v = '0;
      for (int i = 0; i < 32; i++) v[i] = bm[i];
      return v;
   endfunction

   function automatic int mcnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += bm[i];
      return c;
   endfunction

   // A register is a hazard if busy, unless (bypass build) it is released this cycle.
   function automatic bit hz(input int i);
      bit released = (av && ar == i) || (lv && lr == i);
`ifdef AQ_IDU_SB_WB_BYPASS_EN
      return bm[i] && !released;
`else
      return bm[i] && (released || !released);
`endif
   endfunction

   task automatic idle();
      dv = 0; rdv = 0; r1v = 0; r2v = 0; av = 0; lv = 0; fl = 0;
      rd = 0; r1 = 0; r2 = 0; ar = 0; lr = 0;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".busy"},  busy, mvec());
      chk({tag, ".cnt"},   {26'h0, cnt}, 32'(mcnt()));
      chk({tag, ".empty"}, {31'h0, empty}, {31'h0, mcnt() == 0});
   endtask

   // Inputs are set at posedge+1; stall is checked before the edge, state after it.
   task automatic cyc(input string tag);
      bit fire;
      #2;
      exp_stall = dv && (fl || (r1v && hz(r1)) || (r2v && hz(r2)) || (rdv && hz(rd)));
      chk({tag, ".stall"}, {31'h0, stall}, {31'h0, exp_stall});
      fire = dv && !exp_stall;
      @(posedge clk);
      if (fl) begin
         for (int i = 0; i < 32; i++) bm[i] = 0;
      end else begin
         if (av) bm[ar] = 0;
         if (lv) bm[lr] = 0;
         if (fire && rdv && rd != 0) bm[rd] = 1;
      end
      #1;
      chk_state(tag);
   endtask

   task automatic disp_rd(input int r, input string tag);
      idle(); dv = 1; rdv = 1; rd = 5'(r);
      cyc(tag);
   endtask

   initial begin
      idle();
      #1;
      chk_state("reset");
      #1 chk("reset.stall", {31'h0, stall}, 32'h0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // first dispatch sets x5
      disp_rd(5, "d5");
      chk("d5.busy_const", busy, 32'h20);
      chk("d5.cnt_const", {26'h0, cnt}, 32'd1);

      // RAW on x5, then release by ALU writeback
      idle(); dv = 1; r1v = 1; r1 = 5; cyc("raw5");
      chk("raw5.stall_const", {31'h0, exp_stall}, 32'h1);
      idle(); dv = 1; r1v = 1; r1 = 5; av = 1; ar = 5; cyc("raw5wb");
`ifdef AQ_IDU_SB_WB_BYPASS_EN
      chk("raw5wb.bypass", {31'h0, exp_stall}, 32'h0);
`else
      chk("raw5wb.nobypass", {31'h0, exp_stall}, 32'h1);
      idle(); dv = 1; r1v = 1; r1 = 5; cyc("raw5next");
`endif

      // WAW on x7 with concurrent LSU release
      disp_rd(7, "d7");
      saved_cnt = mcnt();
      idle(); dv = 1; rdv = 1; rd = 7; lv = 1; lr = 7; cyc("waw7");
      if (exp_stall) disp_rd(7, "waw7retry");
      chk("waw7.bit", {31'h0, busy[7]}, 32'h1);
      chk("waw7.cnt", {26'h0, cnt}, 32'(saved_cnt));

      // dual release on different indices
      idle(); fl = 1; cyc("fl0");
      disp_rd(3, "d3"); disp_rd(9, "d9");
      idle(); av = 1; ar = 3; lv = 1; lr = 9; cyc("wb3_9");
      chk("wb3_9.busy_const", busy, 32'h0);
      chk("wb3_9.empty_const", {31'h0, empty}, 32'h1);

      // same index on both writeback ports counts once
      disp_rd(6, "d6"); disp_rd(8, "d8");
      idle(); av = 1; ar = 6; lv = 1; lr = 6; cyc("wb6_6");
      chk("wb6_6.cnt_const", {26'h0, cnt}, 32'd1);

      // flush beats concurrent dispatch
      disp_rd(1, "d1"); disp_rd(2, "d2"); disp_rd(31, "d31");
      idle(); fl = 1; dv = 1; rdv = 1; rd = 4; cyc("flush");
      chk("flush.stall_const", {31'h0, exp_stall}, 32'h1);
      chk("flush.busy_const", busy, 32'h0);

      // x0 never becomes busy
      disp_rd(0, "d0");
      idle(); av = 1; ar = 0; cyc("wb0");
      chk("wb0.cnt_const", {26'h0, cnt}, 32'd0);

      // async reset mid-operation; stale writebacks afterwards are ignored
      disp_rd(10, "d10"); disp_rd(11, "d11");
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) bm[i] = 0;
      #1 chk_state("midrst");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      idle(); av = 1; ar = 10; lv = 1; lr = 11; cyc("stalewb");
      chk("stalewb.cnt_const", {26'h0, cnt}, 32'd0);

      // random traffic on a narrow index range to provoke hazards
      for (int n = 0; n < 600; n++) begin
         dv  = 1'($urandom_range(0, 3) != 0);
         rdv = 1'($urandom);  rd = 5'($urandom_range(0, 9));
         r1v = 1'($urandom);  r1 = 5'($urandom_range(0, 9));
         r2v = 1'($urandom);  r2 = 5'($urandom_range(0, 9));
         av  = 1'($urandom);  ar = 5'($urandom_range(0, 9));
         lv  = 1'($urandom);  lr = 5'($urandom_range(0, 9));
         fl  = 1'($urandom_range(0, 40) == 0);
         if (n % 50 == 49) begin
            rd = 5'($urandom); r1 = 5'($urandom); ar = 5'($urandom);
         end
         cyc("rnd");
      end

      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
